// File: rtl/data_mem_lsu.sv
// data_mem_lsu
//   Byte-addressed data memory with a load/store front end for the MIPS MEM
//   stage. It handles byte, halfword and word accesses with big-endian lanes,
//   signed or unsigned loads, a configurable read latency and a hardware clear
//   of the whole array after every reset. Requests that are misaligned, that
//   fall outside the address window or that use an illegal size complete with
//   rsp_err=1 and never touch the array.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  block can accept a request this cycle
//   req_write  1 = store, 0 = load
//   req_size   00 byte, 01 half, 10 word, 11 illegal
//   req_signed loads only: 1 = sign-extend, 0 = zero-extend
//   req_addr   byte address
//   req_wdata  store data, right-justified
//   rsp_valid  one-cycle completion pulse
//   rsp_rdata  load result (0 for stores and errors), held until next response
//   rsp_err    error flag, qualified by rsp_valid, held until next response
//   init_done  clear sequence finished
module data_mem_lsu #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned DEPTH_BYTES = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
   parameter int unsigned RD_LATENCY  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              init_done
);

   localparam int unsigned ADDR_W      = $clog2(DEPTH_BYTES);
   localparam int unsigned WIDX_W      = ADDR_W - 2;
   localparam int unsigned DEPTH_WORDS = DEPTH_BYTES / 4;
   localparam logic [32:0] WIN_END     = {1'b0, BASE_ADDR} + 33'(DEPTH_BYTES);

   typedef enum logic [1:0] {
      S_INIT,
      S_IDLE,
      S_WR,
      S_RD
   } state_t;

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   state_t            state;
   logic [WIDX_W-1:0] init_cnt;
   logic [2:0]        lat_cnt;

   // Fields captured at acceptance; only the store path needs them later.
   logic [WIDX_W-1:0] cap_widx;
   logic [1:0]        cap_lane;
   logic [1:0]        cap_size;
   logic [DATA_W-1:0] cap_wdata;
   logic              cap_err;

   // Load result computed at acceptance, presented when the latency expires.
   logic [DATA_W-1:0] pend_rdata;
   logic              pend_err;

   // Request decode (live inputs, used at the accepting edge)
   logic [ADDR_W-1:0] offset;
   logic [WIDX_W-1:0] widx;
   logic [1:0]        lane;
   logic [32:0]       nbytes;
   logic [32:0]       end_addr;
   logic              req_err;
   logic [DATA_W-1:0] rd_word;
   logic [7:0]        sel_b;
   logic [15:0]       sel_h;
   logic [DATA_W-1:0] ld_data;
   logic [DATA_W-1:0] rd_result;

   always_comb begin
      offset   = ADDR_W'(req_addr - BASE_ADDR);
      widx     = offset[ADDR_W-1:2];
      lane     = offset[1:0];

      unique case (req_size)
         2'b00:   nbytes = 33'd1;
         2'b01:   nbytes = 33'd2;
         2'b10:   nbytes = 33'd4;
         default: nbytes = 33'd1;
      endcase

      // 33-bit sum so an access near 32'hFFFF_FFFF cannot wrap into the window.
      end_addr = {1'b0, req_addr} + nbytes - 33'd1;

      req_err  = (req_addr < BASE_ADDR)
               | (end_addr >= WIN_END)
               | (req_size == 2'b11)
               | ((req_size == 2'b01) & lane[0])
               | ((req_size == 2'b10) & (lane != 2'b00));

      rd_word  = mem[widx];

      // Big-endian: lane 0 is the most significant byte of the word.
      unique case (lane)
         2'd0:    sel_b = rd_word[31:24];
         2'd1:    sel_b = rd_word[23:16];
         2'd2:    sel_b = rd_word[15:8];
         default: sel_b = rd_word[7:0];
      endcase
      sel_h = lane[1] ? rd_word[15:0] : rd_word[31:16];

      unique case (req_size)
         2'b00:   ld_data = req_signed ? {{24{sel_b[7]}}, sel_b} : {24'b0, sel_b};
         2'b01:   ld_data = req_signed ? {{16{sel_h[15]}}, sel_h} : {16'b0, sel_h};
         2'b10:   ld_data = rd_word;
         default: ld_data = '0;
      endcase

      rd_result = req_err ? '0 : ld_data;
   end

   // Store lane enables and lane-replicated data (be[3] is lane 0 = [31:24]).
   logic [3:0]        be;
   logic [DATA_W-1:0] wword;

   always_comb begin
      be    = '0;
      wword = cap_wdata;
      unique case (cap_size)
         2'b00: begin
            be    = 4'b1000 >> cap_lane;
            wword = {4{cap_wdata[7:0]}};
         end
         2'b01: begin
            be    = cap_lane[1] ? 4'b0011 : 4'b1100;
            wword = {2{cap_wdata[15:0]}};
         end
         2'b10: begin
            be    = 4'b1111;
            wword = cap_wdata;
         end
         default: be = '0;
      endcase
   end

   // Array has no reset; it is cleared by the INIT walk instead.
   always_ff @(posedge clk) begin
      if (state == S_INIT) begin
         mem[init_cnt] <= '0;
      end else if (state == S_WR && !cap_err) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem[cap_widx][8*i +: 8] <= wword[8*i +: 8];
            end
         end
      end
   end

   // Control FSM. rsp_valid is raised on the edge that enters the response
   // cycle, so the WR cycle itself (or the last RD cycle) carries the pulse and
   // the following cycle is IDLE with req_ready=1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_INIT;
         init_cnt   <= '0;
         init_done  <= 1'b0;
         req_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         lat_cnt    <= '0;
         cap_widx   <= '0;
         cap_lane   <= '0;
         cap_size   <= '0;
         cap_wdata  <= '0;
         cap_err    <= 1'b0;
         pend_rdata <= '0;
         pend_err   <= 1'b0;
      end else begin
         unique case (state)
            S_INIT: begin
               if (init_cnt == WIDX_W'(DEPTH_WORDS - 1)) begin
                  state     <= S_IDLE;
                  init_done <= 1'b1;
                  req_ready <= 1'b1;
               end else begin
                  init_cnt <= init_cnt + 1'b1;
               end
            end

            S_IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  cap_widx  <= widx;
                  cap_lane  <= lane;
                  cap_size  <= req_size;
                  cap_wdata <= req_wdata;
                  cap_err   <= req_err;
                  if (req_write) begin
                     state     <= S_WR;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= '0;
                     rsp_err   <= req_err;
                  end else begin
                     state   <= S_RD;
                     lat_cnt <= 3'(RD_LATENCY - 1);
                     if (RD_LATENCY == 1) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rd_result;
                        rsp_err   <= req_err;
                     end else begin
                        pend_rdata <= rd_result;
                        pend_err   <= req_err;
                     end
                  end
               end
            end

            S_WR: begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end

            S_RD: begin
               if (lat_cnt == 3'd0) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
                  if (lat_cnt == 3'd1) begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= pend_rdata;
                     rsp_err   <= pend_err;
                  end
               end
            end

            default: state <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_lsu.sv
module tb_data_mem_lsu;

   localparam logic [31:0] BASE  = 32'h0000_0400;
   localparam int          DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   // Index 0: default build (RD_LATENCY=1); index 1: RD_LATENCY=3 build.
   logic [1:0]  req_valid, req_ready, req_write, req_signed;
   logic [1:0]  rsp_valid, rsp_err, init_done;
   logic [1:0]  req_size  [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [31:0] rsp_rdata [2];

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mdl [2][DEPTH];

   always #5 clk = ~clk;

   data_mem_lsu #(.DEPTH_BYTES(1024), .BASE_ADDR(32'h0000_0400), .RD_LATENCY(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_err(rsp_err[0]), .init_done(init_done[0]));

   data_mem_lsu #(.DEPTH_BYTES(1024), .BASE_ADDR(32'h0000_0400), .RD_LATENCY(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_err(rsp_err[1]), .init_done(init_done[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic int lat_of(input int d, input bit wr);
      if (wr) return 1;
      return (d == 0) ? 1 : 3;
   endfunction

   task automatic model_clear();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < DEPTH; i++) mdl[d][i] = 8'h00;
   endtask

   // Reference: window/alignment rules on plain integers, memory as bytes in
   // address order (lowest address = most significant byte of a word).
   task automatic model_op(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] erd, output bit eer);
      int n;
      int o;
      longint aa;
      logic [31:0] v;
      n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
      aa  = longint'(a);
      eer = (n == 0) || (aa < longint'(BASE)) || (aa + n - 1 >= longint'(BASE) + DEPTH);
      if (!eer && (((aa - longint'(BASE)) % n) != 0)) eer = 1'b1;
      erd = 32'h0;
      if (!eer) begin
         o = int'(aa - longint'(BASE));
         if (wr) begin
            for (int k = 0; k < n; k++) mdl[d][o+k] = 8'(wd >> (8 * (n - 1 - k)));
         end else begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v = (v << 8) | {24'h0, mdl[d][o+k]};
            if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            erd = v;
         end
      end
   endtask

   // One transaction; inputs change and outputs are sampled 1 time unit after posedge.
   task automatic xact(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output bit er, output int lat);
      int w;
      bit busy_ready;
      w = 0;
      while (!req_ready[d] && w < 2000) begin
         @(posedge clk); #1; w++;
      end
      chk($sformatf("ready_before_req d%0d", d), 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b1; req_write[d] = wr; req_size[d] = sz; req_signed[d] = sg;
      req_addr[d] = a; req_wdata[d] = wd;
      @(posedge clk); #1;
      // Fields must have been captured; scramble them.
      req_valid[d] = 1'b0; req_write[d] = 1'($urandom); req_size[d] = 2'($urandom);
      req_signed[d] = 1'($urandom); req_addr[d] = $urandom; req_wdata[d] = $urandom;
      lat = 1;
      busy_ready = 1'b0;
      while (!rsp_valid[d] && lat < 20) begin
         if (req_ready[d]) busy_ready = 1'b1;
         @(posedge clk); #1; lat++;
      end
      if (req_ready[d]) busy_ready = 1'b1;
      rd = rsp_rdata[d];
      er = rsp_err[d];
      chk($sformatf("ready_low_while_busy d%0d", d), 32'(busy_ready), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("single_pulse d%0d", d), 32'(rsp_valid[d]), 32'd0);
      chk($sformatf("rdata_hold d%0d", d), rsp_rdata[d], rd);
   endtask

   task automatic do_op(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] erd, rd;
      bit eer, er;
      int lat;
      model_op(d, wr, sz, sg, a, wd, erd, eer);
      xact(d, wr, sz, sg, a, wd, rd, er, lat);
      chk($sformatf("op d%0d wr%0d sz%0d a=%08h rdata", d, wr, sz, a), rd, erd);
      chk($sformatf("op d%0d wr%0d sz%0d a=%08h err", d, wr, sz, a), 32'(er), 32'(eer));
      chk($sformatf("op d%0d wr%0d latency", d, wr), 32'(lat), 32'(lat_of(d, wr)));
   endtask

   task automatic release_and_init();
      int k;
      int done_at [2];
      bit bad [2];
      done_at[0] = -1; done_at[1] = -1; bad[0] = 0; bad[1] = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      k = 0;
      while ((done_at[0] < 0 || done_at[1] < 0) && k < 600) begin
         @(posedge clk); #1; k++;
         for (int d = 0; d < 2; d++) begin
            if (done_at[d] < 0) begin
               if (init_done[d]) done_at[d] = k;
               else if (req_ready[d] || rsp_valid[d]) bad[d] = 1'b1;
            end
         end
      end
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("init_done_cycles d%0d", d), 32'(done_at[d]), 32'd256);
         chk($sformatf("quiet_during_init d%0d", d), 32'(bad[d]), 32'd0);
         chk($sformatf("ready_after_init d%0d", d), 32'(req_ready[d]), 32'd1);
      end
   endtask

   typedef struct {
      bit          wr;
      logic [1:0]  sz;
      bit          sg;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      bit          exp_er;
   } vec_t;

   vec_t tbl [$];

   initial begin : main
      logic [31:0] rd, erd;
      bit er, eer;
      int lat;
      int hist [64];
      int n_acc, n_rsp, bad_t, bad_d, bad_r;
      logic [31:0] exp400;
      logic [31:0] a;
      logic [1:0] sz;
      int n;

      req_valid = '0; req_write = '0; req_signed = '0;
      for (int d = 0; d < 2; d++) begin
         req_size[d] = 2'b10; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
      end
      model_clear();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset req_ready d%0d", d), 32'(req_ready[d]), 32'd0);
         chk($sformatf("reset rsp_valid d%0d", d), 32'(rsp_valid[d]), 32'd0);
         chk($sformatf("reset rsp_rdata d%0d", d), rsp_rdata[d], 32'd0);
         chk($sformatf("reset rsp_err d%0d", d), 32'(rsp_err[d]), 32'd0);
         chk($sformatf("reset init_done d%0d", d), 32'(init_done[d]), 32'd0);
      end
      release_and_init();

      // Directed vectors on the latency-1 build
      tbl.push_back('{0, 2'b10, 0, 32'h400, 32'h0,        32'h0000_0000, 0});
      tbl.push_back('{1, 2'b10, 0, 32'h400, 32'hDEADBEEF, 32'h0000_0000, 0});
      tbl.push_back('{0, 2'b10, 0, 32'h400, 32'h0,        32'hDEADBEEF, 0});
      tbl.push_back('{0, 2'b00, 1, 32'h400, 32'h0,        32'hFFFFFFDE, 0});
      tbl.push_back('{0, 2'b00, 0, 32'h401, 32'h0,        32'h000000AD, 0});
      tbl.push_back('{0, 2'b01, 1, 32'h402, 32'h0,        32'hFFFFBEEF, 0});
      tbl.push_back('{0, 2'b01, 0, 32'h402, 32'h0,        32'h0000BEEF, 0});
      tbl.push_back('{0, 2'b10, 1, 32'h400, 32'h0,        32'hDEADBEEF, 0});
      tbl.push_back('{1, 2'b00, 0, 32'h403, 32'hFFFF_FF12, 32'h0000_0000, 0});
      tbl.push_back('{0, 2'b10, 0, 32'h400, 32'h0,        32'hDEADBE12, 0});
      tbl.push_back('{1, 2'b01, 0, 32'h400, 32'hABCD_0042, 32'h0000_0000, 0});
      tbl.push_back('{0, 2'b10, 0, 32'h400, 32'h0,        32'h0042BE12, 0});
      tbl.push_back('{0, 2'b10, 0, 32'h402, 32'h0,        32'h0000_0000, 1});
      tbl.push_back('{0, 2'b01, 1, 32'h401, 32'h0,        32'h0000_0000, 1});
      tbl.push_back('{0, 2'b10, 0, 32'h3FC, 32'h0,        32'h0000_0000, 1});
      tbl.push_back('{1, 2'b10, 0, 32'h800, 32'h1111_1111, 32'h0000_0000, 1});
      tbl.push_back('{0, 2'b11, 0, 32'h400, 32'h0,        32'h0000_0000, 1});
      tbl.push_back('{1, 2'b11, 0, 32'h400, 32'hFFFF_FFFF, 32'h0000_0000, 1});
      tbl.push_back('{0, 2'b10, 0, 32'h400, 32'h0,        32'h0042BE12, 0});
      tbl.push_back('{1, 2'b00, 0, 32'h7FF, 32'h0000_00A5, 32'h0000_0000, 0});
      tbl.push_back('{0, 2'b00, 1, 32'h7FF, 32'h0,        32'hFFFFFFA5, 0});
      tbl.push_back('{0, 2'b10, 0, 32'h7FC, 32'h0,        32'h000000A5, 0});
      tbl.push_back('{0, 2'b01, 0, 32'h7FE, 32'h0,        32'h000000A5, 0});
      tbl.push_back('{0, 2'b00, 0, 32'h800, 32'h0,        32'h0000_0000, 1});
      tbl.push_back('{0, 2'b01, 0, 32'h3FF, 32'h0,        32'h0000_0000, 1});
      tbl.push_back('{0, 2'b10, 0, 32'hFFFF_FFFC, 32'h0,  32'h0000_0000, 1});

      foreach (tbl[i]) begin
         model_op(0, tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, erd, eer);
         xact(0, tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, rd, er, lat);
         chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
         chk($sformatf("vec%0d err", i), 32'(er), 32'(tbl[i].exp_er));
         chk($sformatf("vec%0d latency", i), 32'(lat), 32'(lat_of(0, tbl[i].wr)));
      end

      // Back-to-back loads on the latency-3 build with req_valid held high
      do_op(1, 1, 2'b10, 0, 32'h400, 32'hCAFE_F00D);
      model_op(1, 0, 2'b10, 0, 32'h400, 32'h0, exp400, eer);
      @(posedge clk); #1;
      req_valid[1] = 1'b1; req_write[1] = 1'b0; req_size[1] = 2'b10;
      req_signed[1] = 1'b0; req_addr[1] = 32'h400;
      n_acc = 0; n_rsp = 0; bad_t = 0; bad_d = 0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         hist[c] = int'(req_valid[1] & req_ready[1]);
         n_acc += hist[c];
         if (rsp_valid[1]) begin
            n_rsp++;
            if (rsp_rdata[1] !== exp400 || rsp_err[1] !== 1'b0) bad_d++;
         end
         if (int'(rsp_valid[1]) != ((c >= 3) ? hist[c-3] : 0)) bad_t++;
      end
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      chk("b2b accept count", 32'(n_acc), 32'd6);
      chk("b2b response count", 32'(n_rsp), 32'd6);
      chk("b2b 3-cycle timing", 32'(bad_t), 32'd0);
      chk("b2b response data", 32'(bad_d), 32'd0);

      // Randomized traffic against the byte model on both builds
      for (int d = 0; d < 2; d++) begin
         for (int t = 0; t < 150; t++) begin
            n = $urandom_range(0, 19);
            if (n < 16)      a = BASE + $urandom_range(0, DEPTH - 1);
            else if (n < 18) a = 32'h3F8 + $urandom_range(0, 15);
            else if (n < 19) a = 32'h7F8 + $urandom_range(0, 15);
            else             a = $urandom;
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            do_op(d, 1'($urandom), sz, 1'($urandom), a, $urandom);
         end
      end

      // Reset one cycle after a load is accepted on the latency-3 build
      do_op(1, 1, 2'b10, 0, 32'h400, 32'h1357_9BDF);
      do_op(0, 1, 2'b10, 0, 32'h400, 32'h2468_ACE0);
      req_valid[1] = 1'b1; req_write[1] = 1'b0; req_size[1] = 2'b10; req_addr[1] = 32'h400;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      bad_r = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (rsp_valid[1] || init_done[1] || req_ready[1]) bad_r++;
      end
      chk("no rsp for dropped load", 32'(bad_r), 32'd0);
      model_clear();
      release_and_init();
      do_op(1, 0, 2'b10, 0, 32'h400, 32'h0);
      do_op(0, 0, 2'b10, 0, 32'h400, 32'h0);
      xact(1, 0, 2'b10, 0, 32'h400, 32'h0, rd, er, lat);
      chk("0x400 cleared after reset", rd, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
